// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port synchronous RAM/ROM between the Z80 bus
// and a loader/debug port, round-robin on ties, stalling the CPU via wait_n.
//
// Ports:
//   clk, reset             system clock, async active-high reset
//   cpu_mreq_n/rd_n/wr_n   Z80 strobes (active low, synchronous to clk)
//   cpu_a, cpu_dout        CPU address / write data
//   cpu_din                registered read data to the CPU bus mux
//   cpu_wait_n             CPU stall, active low (combinational)
//   ldr_req/we/a/wdata     loader request level, direction, address, data
//   ldr_ack, ldr_rdata     one-cycle completion pulse, loader read data
//   mem_a/we/din           registered memory address, write enable, data
//   mem_dout               memory read data, valid one clk after address
//
// Build option: define MEM_ARB_ROM_PROTECT_EN to block CPU writes below
// ROM_TOP (the CPU cycle still runs full length, memory is untouched).

module mem_arbiter #(
    parameter int            AW      = 8,
    parameter int            DW      = 8,
    parameter logic [AW-1:0] ROM_TOP = 'h40
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_mreq_n,
    input  logic          cpu_rd_n,
    input  logic          cpu_wr_n,
    input  logic [AW-1:0] cpu_a,
    input  logic [DW-1:0] cpu_dout,
    output logic [DW-1:0] cpu_din,
    output logic          cpu_wait_n,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_a,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_ack,
    output logic [DW-1:0] ldr_rdata,
    output logic [AW-1:0] mem_a,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] C_ACC  = 3'd1;
    localparam logic [2:0] C_DONE = 3'd2;
    localparam logic [2:0] L_ACC  = 3'd3;
    localparam logic [2:0] L_DONE = 3'd4;

    localparam logic G_CPU = 1'b0;
    localparam logic G_LDR = 1'b1;

`ifdef MEM_ARB_ROM_PROTECT_EN
    localparam logic PROTECT = 1'b1;
`else
    localparam logic PROTECT = 1'b0;
`endif

    logic [2:0] state;
    logic       cpu_done;
    logic       last_grant;

    logic cpu_req;
    logic cpu_pend;
    logic cpu_we;
    logic grant_cpu;
    logic grant_ldr;

    assign cpu_req  = !cpu_mreq_n && (!cpu_rd_n || !cpu_wr_n);
    // cpu_done blocks a second access within the same Z80 cycle.
    assign cpu_pend = cpu_req && !cpu_done;
    assign cpu_wait_n = !cpu_pend;

    // Protected writes keep full timing but never raise mem_we.
    assign cpu_we = !cpu_wr_n && !(PROTECT && (cpu_a < ROM_TOP));

    // On a tie the side that did not win last time is served.
    assign grant_cpu = cpu_pend && (!ldr_req || last_grant == G_LDR);
    assign grant_ldr = ldr_req && !grant_cpu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cpu_done   <= 1'b0;
            last_grant <= G_LDR;
            cpu_din    <= '0;
            ldr_rdata  <= '0;
            ldr_ack    <= 1'b0;
            mem_a      <= '0;
            mem_we     <= 1'b0;
            mem_din    <= '0;
        end else begin
            ldr_ack <= 1'b0;
            if (cpu_mreq_n)
                cpu_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        mem_a      <= cpu_a;
                        mem_din    <= cpu_dout;
                        mem_we     <= cpu_we;
                        last_grant <= G_CPU;
                        state      <= C_ACC;
                    end else if (grant_ldr) begin
                        mem_a      <= ldr_a;
                        mem_din    <= ldr_wdata;
                        mem_we     <= ldr_we;
                        last_grant <= G_LDR;
                        state      <= L_ACC;
                    end
                end
                C_ACC: begin
                    mem_we <= 1'b0;
                    state  <= C_DONE;
                end
                C_DONE: begin
                    cpu_din <= mem_dout;
                    // If the strobes already dropped, the clear wins so the
                    // next Z80 cycle is not swallowed.
                    if (!cpu_mreq_n)
                        cpu_done <= 1'b1;
                    state <= IDLE;
                end
                L_ACC: begin
                    mem_we <= 1'b0;
                    state  <= L_DONE;
                end
                L_DONE: begin
                    ldr_rdata <= mem_dout;
                    ldr_ack   <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// behavioural 256x8 synchronous memory attached to the mem_* port.

module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_mreq_n, cpu_rd_n, cpu_wr_n;
    logic [7:0] cpu_a, cpu_dout, cpu_din;
    logic       cpu_wait_n;
    logic       ldr_req, ldr_we, ldr_ack;
    logic [7:0] ldr_a, ldr_wdata, ldr_rdata;
    logic [7:0] mem_a, mem_din, mem_dout;
    logic       mem_we;

    logic       pl_en = 1'b0;
    logic [7:0] pl_a = 8'h00;
    logic [7:0] pl_d = 8'h00;
    logic [7:0] mem [256];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(8), .DW(8), .ROM_TOP(8'h40)) dut (
        .clk(clk), .reset(reset),
        .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .cpu_wait_n(cpu_wait_n),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_a(ldr_a),
        .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_a(mem_a), .mem_we(mem_we), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_a] <= pl_d;
        else if (mem_we)
            mem[mem_a] <= mem_din;
        mem_dout <= mem[mem_a];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_a = a; pl_d = d; pl_en = 1'b1;
        step();
        pl_en = 1'b0;
    endtask

    task automatic idle_inputs();
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        cpu_a = 8'h00; cpu_dout = 8'h00;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_a = 8'h00; ldr_wdata = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Runs one CPU access; returns clocks until wait_n rose (20 = timeout).
    task automatic cpu_access(input logic [7:0] a, input logic wr,
                              input logic [7:0] d,
                              output int waits, output logic [7:0] din,
                              output int we_seen);
        cpu_a = a; cpu_dout = d;
        cpu_mreq_n = 1'b0;
        cpu_rd_n = wr; cpu_wr_n = !wr;
        waits = 20; we_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (mem_we) we_seen++;
            if (cpu_wait_n) begin
                waits = i;
                break;
            end
        end
        din = cpu_din;
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        step();
    endtask

    // Both sides request reads on the same edge.
    task automatic run_tie(input logic [7:0] ca, input logic [7:0] la,
                           output logic [7:0] first_a,
                           output int cpu_cyc, output int ack_cyc,
                           output logic [7:0] cdat, output logic [7:0] ldat);
        cpu_a = ca; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b1;
        ldr_a = la; ldr_we = 1'b0; ldr_req = 1'b1;
        cpu_cyc = 0; ack_cyc = 0; first_a = 8'hxx;
        cdat = 8'hxx; ldat = 8'hxx;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 1) first_a = mem_a;
            if (ldr_ack && ack_cyc == 0) begin
                ack_cyc = i;
                ldat = ldr_rdata;
                ldr_req = 1'b0;
            end
            if (cpu_wait_n && cpu_cyc == 0) begin
                cpu_cyc = i;
                cdat = cpu_din;
            end
            if (cpu_cyc != 0 && ack_cyc != 0) break;
        end
        ldr_req = 1'b0;
        cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #3;
        n_checks++;
        if (cpu_wait_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_wait_n got %b want 1", cpu_wait_n);
        end
        n_checks++;
        if ({cpu_din, ldr_rdata, mem_a, mem_din} !== 32'h0 ||
            mem_we !== 1'b0 || ldr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs got din=%h rd=%h a=%h d=%h we=%b ack=%b want all 0",
                     cpu_din, ldr_rdata, mem_a, mem_din, mem_we, ldr_ack);
        end
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_cpu_read();
        int w, we; logic [7:0] d;
        cpu_access(8'h10, 1'b0, 8'h00, w, d, we);
        n_checks++;
        if (w !== 3) begin
            n_fail++;
            $display("FAIL cpu_read_wait got %0d want 3", w);
        end
        n_checks++;
        if (d !== 8'h3E) begin
            n_fail++;
            $display("FAIL cpu_read_data got %h want 3e", d);
        end
        n_checks++;
        if (we !== 0) begin
            n_fail++;
            $display("FAIL cpu_read_we got %0d want 0", we);
        end
    endtask

    task automatic test_loader_write();
        int cyc, w, we; logic [7:0] d;
        ldr_a = 8'h20; ldr_wdata = 8'h55; ldr_we = 1'b1; ldr_req = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (ldr_ack) begin
                cyc = i;
                break;
            end
        end
        ldr_req = 1'b0; ldr_we = 1'b0;
        n_checks++;
        if (cyc !== 3) begin
            n_fail++;
            $display("FAIL ldr_ack_latency got %0d want 3", cyc);
        end
        step();
        n_checks++;
        if (ldr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL ldr_ack_pulse got %b want 0", ldr_ack);
        end
        n_checks++;
        if (mem[8'h20] !== 8'h55) begin
            n_fail++;
            $display("FAIL ldr_write_mem got %h want 55", mem[8'h20]);
        end
        cpu_access(8'h20, 1'b0, 8'h00, w, d, we);
        n_checks++;
        if (d !== 8'h55 || w !== 3) begin
            n_fail++;
            $display("FAIL cpu_read_back got %h/%0d want 55/3", d, w);
        end
    endtask

    task automatic test_tie();
        logic [7:0] fa, cd, ld, d; int cc, ac, w, we;
        do_reset();
        run_tie(8'h10, 8'h20, fa, cc, ac, cd, ld);
        n_checks++;
        if (fa !== 8'h10 || cc !== 3 || ac !== 6) begin
            n_fail++;
            $display("FAIL tie_cpu_first got a=%h cpu=%0d ack=%0d want 10/3/6",
                     fa, cc, ac);
        end
        n_checks++;
        if (cd !== 8'h3E || ld !== 8'h55) begin
            n_fail++;
            $display("FAIL tie1_data got %h/%h want 3e/55", cd, ld);
        end
        // A lone CPU access leaves the CPU as last winner.
        cpu_access(8'h10, 1'b0, 8'h00, w, d, we);
        run_tie(8'h10, 8'h20, fa, cc, ac, cd, ld);
        n_checks++;
        if (fa !== 8'h20 || ac !== 3 || cc !== 6) begin
            n_fail++;
            $display("FAIL tie_ldr_first got a=%h ack=%0d cpu=%0d want 20/3/6",
                     fa, ac, cc);
        end
        n_checks++;
        if (cd !== 8'h3E || ld !== 8'h55) begin
            n_fail++;
            $display("FAIL tie2_data got %h/%h want 3e/55", cd, ld);
        end
    endtask

    task automatic test_long_strobe();
        int low, back;
        for (int pass = 0; pass < 2; pass++) begin
            cpu_a = 8'h10; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
            low = 0; back = 0;
            #0;
            if (!cpu_wait_n) low++;
            for (int i = 1; i <= 12; i++) begin
                step();
                if (!cpu_wait_n) begin
                    low++;
                    if (i > 3) back++;
                end
            end
            n_checks++;
            if (low !== 3 || back !== 0) begin
                n_fail++;
                $display("FAIL long_strobe pass%0d low=%0d relow=%0d want 3/0",
                         pass, low, back);
            end
            cpu_mreq_n = 1'b1; cpu_rd_n = 1'b1;
            step();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] fa, cd, ld; int cc, ac;
        ldr_a = 8'h30; ldr_wdata = 8'h77; ldr_we = 1'b1; ldr_req = 1'b1;
        step();
        n_checks++;
        if (mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL lacc_we got %b want 1", mem_we);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (mem_we !== 1'b0 || ldr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got we=%b ack=%b want 0/0", mem_we, ldr_ack);
        end
        ldr_req = 1'b0; ldr_we = 1'b0;
        step();
        reset = 1'b0;
        step();
        n_checks++;
        if (ldr_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ack got %b want 0", ldr_ack);
        end
        run_tie(8'h10, 8'h20, fa, cc, ac, cd, ld);
        n_checks++;
        if (fa !== 8'h10 || cc !== 3 || ac !== 6) begin
            n_fail++;
            $display("FAIL post_reset_tie got a=%h cpu=%0d ack=%0d want 10/3/6",
                     fa, cc, ac);
        end
    endtask

    task automatic test_rom();
        int w, we; logic [7:0] d, exp;
`ifdef MEM_ARB_ROM_PROTECT_EN
        exp = 8'h11;
`else
        exp = 8'hAA;
`endif
        cpu_access(8'h05, 1'b1, 8'hAA, w, d, we);
        n_checks++;
        if (w !== 3) begin
            n_fail++;
            $display("FAIL rom_write_wait got %0d want 3", w);
        end
        n_checks++;
        if (mem[8'h05] !== exp) begin
            n_fail++;
            $display("FAIL rom_write_mem got %h want %h", mem[8'h05], exp);
        end
        cpu_access(8'h05, 1'b0, 8'h00, w, d, we);
        n_checks++;
        if (d !== exp) begin
            n_fail++;
            $display("FAIL rom_read_back got %h want %h", d, exp);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        preload(8'h10, 8'h3E);
        preload(8'h05, 8'h11);
        test_reset();
        test_cpu_read();
        test_loader_write();
        test_tie();
        test_long_strobe();
        test_reset_mid();
        test_rom();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
